// File: rtl/rtc_bus_ctrl.sv
// PicoBlaze port-mapped bridge to a multiplexed address/data RTC bus.
// Optional macro RTC_IRQ_EN adds a transaction-done interrupt; without it software polls busy.
module rtc_bus_ctrl #(
  parameter logic [7:0]  PORT_ADDR    = 8'h10,
  parameter logic [7:0]  PORT_WDATA   = 8'h11,
  parameter logic [7:0]  PORT_RCMD    = 8'h12,
  parameter logic [7:0]  PORT_RDATA   = 8'h13,
  parameter int unsigned PHASE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic       interrupt_ack,
  output logic [7:0] in_port,
  output logic       interrupt,
  output logic       rtc_cs_n,
  output logic       rtc_ad_n,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  input  logic [7:0] rtc_ad_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_A_SET, S_A_STB, S_A_HLD, S_D_SET, S_D_STB, S_D_HLD, S_DONE
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(PHASE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, bus_addr_q, bus_addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, in_port_q;
  logic       dir_q, dir_d;
  logic       err_q, rd_valid_q;
  logic       cs_n_q, ad_n_q, wr_n_q, rd_n_q, ad_oe_q;
  logic       cs_n_d, ad_n_d, wr_n_d, rd_n_d, ad_oe_d;
  logic [7:0] ad_out_q, ad_out_d;

  logic wr_addr, wr_wdata, wr_rcmd, rd_stat, rd_data;
  logic busy, start, collide, phase_end, enter_done;
  logic [7:0] status;

  assign wr_addr    = write_strobe && (port_id == PORT_ADDR);
  assign wr_wdata   = write_strobe && (port_id == PORT_WDATA);
  assign wr_rcmd    = write_strobe && (port_id == PORT_RCMD);
  assign rd_stat    = read_strobe  && (port_id == PORT_RCMD);
  assign rd_data    = read_strobe  && (port_id == PORT_RDATA);
  assign busy       = (state_q != S_IDLE);
  assign start      = (wr_wdata || wr_rcmd) && !busy;
  assign collide    = (wr_wdata || wr_rcmd) && busy;
  assign phase_end  = (cnt_q == LAST_CNT);
  assign enter_done = (state_q == S_D_HLD) && phase_end;
  assign status     = {5'b0, err_q, rd_valid_q, busy};

  // Transaction context is captured only at start, so a rejected start or a
  // later address write can never disturb the cycle already on the bus.
  assign dir_d      = start ? wr_rcmd : dir_q;
  assign bus_addr_d = start ? addr_q : bus_addr_q;
  assign wdata_d    = (start && wr_wdata) ? out_port : wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_A_SET;
          cnt_d   = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (phase_end) begin
          cnt_d = '0;
          unique case (state_q)
            S_A_SET: state_d = S_A_STB;
            S_A_STB: state_d = S_A_HLD;
            S_A_HLD: state_d = S_D_SET;
            S_D_SET: state_d = S_D_STB;
            S_D_STB: state_d = S_D_HLD;
            default: state_d = S_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // Bus pins are decoded from the next state so the registered pins line up
  // with state_q exactly.
  always_comb begin
    cs_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    unique case (state_d)
      S_A_SET, S_A_STB, S_A_HLD: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = bus_addr_d;
        if (state_d == S_A_STB) wr_n_d = 1'b0;
      end
      S_D_SET, S_D_STB, S_D_HLD: begin
        cs_n_d = 1'b0;
        if (!dir_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end
        if (state_d == S_D_STB) begin
          if (dir_d) rd_n_d = 1'b0;
          else       wr_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n_q     <= 1'b1;
      ad_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= '0;
      dir_q      <= 1'b0;
      bus_addr_q <= '0;
      wdata_q    <= '0;
    end else begin
      cs_n_q     <= cs_n_d;
      ad_n_q     <= ad_n_d;
      wr_n_q     <= wr_n_d;
      rd_n_q     <= rd_n_d;
      ad_oe_q    <= ad_oe_d;
      ad_out_q   <= ad_out_d;
      dir_q      <= dir_d;
      bus_addr_q <= bus_addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      in_port_q  <= '0;
    end else begin
      if (wr_addr) addr_q <= out_port;
      if ((state_q == S_D_STB) && phase_end) rdata_q <= rtc_ad_in;
      if (collide)      err_q <= 1'b1;
      else if (rd_stat) err_q <= 1'b0;
      if (enter_done && dir_q) rd_valid_q <= 1'b1;
      else if (rd_data)        rd_valid_q <= 1'b0;
      if (port_id == PORT_RCMD)       in_port_q <= status;
      else if (port_id == PORT_RDATA) in_port_q <= rdata_q;
      else                            in_port_q <= '0;
    end
  end

`ifdef RTC_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                irq_q <= 1'b0;
    else if (enter_done)    irq_q <= 1'b1;
    else if (interrupt_ack) irq_q <= 1'b0;
  end

  assign interrupt = irq_q;
`else
  logic unused_ack;
  assign unused_ack = interrupt_ack;
  assign interrupt  = 1'b0;
`endif

  assign in_port    = in_port_q;
  assign rtc_cs_n   = cs_n_q;
  assign rtc_ad_n   = ad_n_q;
  assign rtc_wr_n   = wr_n_q;
  assign rtc_rd_n   = rd_n_q;
  assign rtc_ad_oe  = ad_oe_q;
  assign rtc_ad_out = ad_out_q;

endmodule
